// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI into command words for the RAM and serialises read bytes onto MISO.
// rx_valid pulses the cycle after the last bit; no backpressure, waits on tx_valid indefinitely until SS_n rises.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CW   = DATA_W + 2;
  localparam int RX_W = $clog2(CW + 1);
  localparam int TX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [RX_W-1:0] RX_ONE  = RX_W'(1);
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(CW - 1);
  localparam logic [RX_W-1:0] RX_DONE = RX_W'(CW);
  localparam logic [TX_W-1:0] TX_ONE  = TX_W'(1);
  localparam logic [TX_W-1:0] TX_LAST = TX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t            state;
  logic [RX_W-1:0]   rx_cnt;
  logic [TX_W-1:0]   tx_cnt;
  logic [CW-2:0]     shift_reg;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_active;
  logic              tx_done;
  logic              rd_addr_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_cnt       <= '0;
      tx_cnt       <= '0;
      shift_reg    <= '0;
      tx_shift     <= '0;
      tx_active    <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort: the read-address flag survives so a split read can still complete.
        state     <= IDLE;
        rx_cnt    <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
        tx_done   <= 1'b0;
        MISO      <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            shift_reg <= {shift_reg[CW-3:0], MOSI};
            rx_cnt    <= RX_ONE;
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (rx_cnt != RX_DONE) begin
              shift_reg <= {shift_reg[CW-3:0], MOSI};
              rx_cnt    <= rx_cnt + RX_ONE;
              if (rx_cnt == RX_LAST) begin
                rx_data  <= {shift_reg, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)
                  rd_addr_seen <= 1'b1;
              end
            end else if (state == READ_DATA && !tx_done) begin
              if (!tx_active) begin
                if (tx_valid) begin
                  tx_active <= 1'b1;
                  tx_cnt    <= '0;
                  tx_shift  <= {tx_data[DATA_W-2:0], 1'b0};
                  MISO      <= tx_data[DATA_W-1];
                end
              end else if (tx_cnt != TX_LAST) begin
                MISO     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                tx_cnt   <= tx_cnt + TX_ONE;
              end else begin
                MISO         <= 1'b0;
                tx_active    <= 1'b0;
                tx_done      <= 1'b1;
                rd_addr_seen <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame-level reference model compared every cycle, plus literal expectations.
module tb_spi_slave_if;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  // Frame-level model: p counts consecutive SS_n-low edges of the current frame.
  int         p;
  logic [9:0] word;
  int         kind;      // 0 write, 1 read address, 2 read data
  bit         rd_seen;
  logic [9:0] m_rx_data;
  logic       m_rv;
  logic       m_miso;
  int         tx_start;
  logic [7:0] tx_byte;

  logic       exp_rv;
  logic       exp_miso;
  logic [9:0] exp_rd;
  bit         chk_en;

  int         rv_seen;
  bit         miso_any;
  logic [7:0] hist;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    p = 0; word = '0; kind = 0; rd_seen = 0;
    m_rx_data = '0; m_rv = 0; m_miso = 0; tx_start = -1; tx_byte = '0;
  endtask

  task automatic model_edge(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    int k;
    m_rv = 1'b0;
    if (ss) begin
      p = 0;
      m_miso = 1'b0;
      tx_start = -1;
    end else begin
      if (p < 1000) p = p + 1;
      if (p == 1) tx_start = -1;
      if (p >= 2 && p <= 11) word = {word[8:0], mosi};
      if (p == 2) kind = mosi ? (rd_seen ? 2 : 1) : 0;
      if (p == 11) begin
        m_rx_data = word;
        m_rv = 1'b1;
        if (kind == 1) rd_seen = 1;
      end
      if (p >= 12 && kind == 2) begin
        if (tx_start < 0 && txv) begin
          tx_start = p;
          tx_byte = txd;
        end
        if (tx_start >= 0) begin
          k = p - tx_start;
          if (k <= 7) m_miso = tx_byte[7-k];
          else if (k == 8) begin
            m_miso = 1'b0;
            rd_seen = 0;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rx_valid", {31'd0, rx_valid}, {31'd0, exp_rv});
      check("cyc_rx_data", {22'd0, rx_data}, {22'd0, exp_rd});
      check("cyc_miso", {31'd0, MISO}, {31'd0, exp_miso});
    end
  end

  task automatic step(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    model_edge(ss, mosi, txv, txd);
    @(posedge clk);
    exp_rv = m_rv; exp_rd = m_rx_data; exp_miso = m_miso;
    #1;
    if (rx_valid) rv_seen++;
    if (MISO) miso_any = 1;
  endtask

  task automatic frame(input logic [9:0] w, input int nbits, input int extra, input int txj,
                       input logic [7:0] txd, input bit noise, input bit close);
    logic txv;
    rv_seen = 0; miso_any = 0; hist = '0;
    step(1'b0, 1'($urandom), noise & ($urandom_range(0, 3) == 0), 8'($urandom));
    for (int i = 0; i < nbits; i++)
      step(1'b0, w[9-i], noise & ($urandom_range(0, 3) == 0), 8'($urandom));
    for (int j = 0; j < extra; j++) begin
      txv = (j == txj) || (noise && $urandom_range(0, 3) == 0);
      step(1'b0, 1'($urandom), txv, (j == txj) ? txd : 8'($urandom));
      if (txj >= 0 && j >= txj && j < txj + 8) hist = {hist[6:0], MISO};
    end
    if (close) step(1'b1, 1'($urandom), noise & ($urandom_range(0, 3) == 0), 8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    model_reset();
    exp_rv = 0; exp_rd = '0; exp_miso = 0;
    #3;
    check("reset_miso", {31'd0, MISO}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {22'd0, rx_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;

    // Write address with trailing junk bits: single strobe only.
    frame(10'b00_1010_0101, 10, 4, -1, 8'h00, 0, 1);
    check("wr_addr_data", {22'd0, rx_data}, 32'h0A5);
    check("wr_addr_pulses", rv_seen, 32'd1);

    frame(10'b01_0011_1100, 10, 2, -1, 8'h00, 0, 1);
    check("wr_data_data", {22'd0, rx_data}, 32'h13C);
    check("wr_data_pulses", rv_seen, 32'd1);
    check("wr_data_miso", {31'd0, miso_any}, 32'd0);

    frame(10'b10_0000_0111, 10, 3, -1, 8'h00, 0, 1);
    check("rd_addr_data", {22'd0, rx_data}, 32'h207);

    frame(10'b11_0000_0000, 10, 12, 1, 8'hC3, 0, 1);
    check("rd_data_data", {22'd0, rx_data}, 32'h300);
    check("rd_data_miso_seq", {24'd0, hist}, 32'hC3);

    // Address flag was consumed, so this read frame is treated as an address.
    frame(10'b11_0101_0101, 10, 12, 1, 8'hFF, 0, 1);
    check("rd_noaddr_data", {22'd0, rx_data}, 32'h355);
    check("rd_noaddr_miso", {31'd0, miso_any}, 32'd0);

    frame(10'b11_1010_1010, 10, 12, 0, 8'h5A, 0, 1);
    check("rd_after_noaddr_seq", {24'd0, hist}, 32'h5A);

    frame(10'b00_1111_0000, 5, 0, -1, 8'h00, 0, 1);
    check("abort_pulses", rv_seen, 32'd0);
    check("abort_rx_data", {22'd0, rx_data}, 32'h3AA);
    frame(10'b01_1111_0000, 10, 0, -1, 8'h00, 0, 1);
    check("after_abort_data", {22'd0, rx_data}, 32'h1F0);
    check("after_abort_pulses", rv_seen, 32'd1);

    frame(10'b00_1100_0011, 9, 0, -1, 8'h00, 0, 1);
    check("abort_edge11_pulses", rv_seen, 32'd0);

    for (int f = 0; f < 200; f++) begin
      frame(10'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10,
            $urandom_range(0, 14), $urandom_range(0, 4), 8'($urandom), 1, 1);
      if ($urandom_range(0, 1) == 1) step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Reset in the middle of a MISO burst.
    frame(10'b10_1010_1010, 10, 2, -1, 8'h00, 0, 1);
    frame(10'b11_1111_1111, 10, 2, 0, 8'hFF, 0, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_rv = 0; exp_rd = '0; exp_miso = 0;
    #1;
    check("arst_miso", {31'd0, MISO}, 32'd0);
    check("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("arst_rx_data", {22'd0, rx_data}, 32'd0);
    SS_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    SS_n = 1'b1;

    frame(10'b11_1100_0011, 10, 12, 1, 8'hA5, 0, 1);
    check("post_reset_data", {22'd0, rx_data}, 32'h3C3);
    check("post_reset_miso", {31'd0, miso_any}, 32'd0);
    check("post_reset_pulses", rv_seen, 32'd1);

    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave front end that feeds the synchronous RAM block: it deserialises MOSI into 10-bit command words (`rx_data[9:8]` = command, `rx_data[7:0]` = address/data) and presents each one with a one-cycle `rx_valid` strobe. For read-data frames it waits for the RAM's `tx_valid`/`tx_data` response and serialises the byte onto MISO, MSB first. The RAM's `din`/`rx_valid` inputs and `dout`/`tx_valid` outputs connect directly to this block.

## Interface
- `DATA_W`, 8, RAM data/address width; the command word is `DATA_W+2` bits.
- `clk` in 1: single clock (SPI serial clock). All sampling is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `SS_n` in 1: slave select, active low; frames a transaction.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial data out, MSB first; 0 when not transmitting.
- `rx_data` out `DATA_W+2`: last complete received word, to RAM `din`.
- `rx_valid` out 1: one-cycle strobe, `rx_data` is new.
- `tx_data` in `DATA_W`: read byte from the RAM.
- `tx_valid` in 1: `tx_data` is valid. Sampled only while waiting for it.

## Operation
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. There is also an internal flag `rd_addr_seen`, which is 0 at reset.
- **SS_n high priority:** `SS_n` sampled high in any state goes to IDLE on that edge. This aborts the frame: the bit counter clears, no `rx_valid` is issued, `MISO` goes to 0, and `rd_addr_seen` is unchanged.
- **IDLE:** `SS_n` sampled low goes to CHK_CMD. `MOSI` is ignored on this edge.
- **CHK_CMD:** `MOSI` is captured as word bit 9 and the counter is set to 1.
  - `MOSI=0`: go to WRITE.
  - `MOSI=1` and `rd_addr_seen=0`: go to READ_ADD.
  - `MOSI=1` and `rd_addr_seen=1`: go to READ_DATA.
- **WRITE / READ_ADD / READ_DATA (receive):** shift in bits 8..0 on the next 9 edges.
  - On the edge that captures bit 0, load `rx_data` with the full word and assert `rx_valid` for exactly one cycle.
  - `rx_data[9:8]` is forwarded unmodified. The block never rewrites the command bits; the RAM decodes them.
- **WRITE after the word:** stay in WRITE and ignore extra `MOSI` bits until `SS_n` goes high.
- **READ_ADD after the word:** on the same edge as `rx_valid`, set `rd_addr_seen=1`. Then hold until `SS_n` goes high.
- **READ_DATA after the word:** wait for `tx_valid`.
  - On the first edge where `tx_valid=1`: latch `tx_data` into the TX shifter and drive `MISO <= tx_data[DATA_W-1]`.
  - The next `DATA_W-1` edges drive the remaining bits in descending order.
  - On the edge after the last bit: `MISO <= 0`, `rd_addr_seen <= 0`, and hold until `SS_n` goes high.
  - `tx_valid` in any other state or phase is ignored.
- **Counters:** RX counter is 4 bits and counts 0..10. TX counter is 3 bits (`clog2(DATA_W)`). Neither counter wraps: once complete, it holds.
- **Registered outputs:** `MISO`, `rx_data` and `rx_valid` are all registered.

## Timing
- **Reset values:** state IDLE, `MISO=0`, `rx_data=0`, `rx_valid=0`, `rd_addr_seen=0`, counters 0. These take effect immediately on `rst_n` falling, independent of `clk`.
- **Frame timing:** edge 1 samples `SS_n` low (IDLE→CHK_CMD), edge 2 samples bit 9, edges 3..11 sample bits 8..0. `rx_valid` is high in the cycle after edge 11.
- **Early deassert:** `SS_n` high on edge 11 itself aborts the frame; no `rx_valid` is issued.
- **Read turnaround:** the RAM registers `tx_valid` at the earliest one edge after it sees `rx_valid`. The first `MISO` bit is driven on the edge that samples `tx_valid=1`. There is no timeout: the block waits until `tx_valid` arrives or `SS_n` rises.
- **Back-to-back frames:** `SS_n` high for one edge, then low, starts a new frame; IDLE lasts a minimum of one cycle.
- **Reset mid-frame:** returns to the reset values; a partial word is never emitted.

## Test plan
- **Async reset:** assert `rst_n=0` between clock edges mid-frame → `MISO`, `rx_valid` and `rx_data` are 0 immediately; after release, state is IDLE.
- **Write address:** `SS_n` low, shift `00_1010_0101` → `rx_data=0x0A5`, `rx_valid` high for exactly 1 cycle after edge 11. Extra `MOSI` bits produce no second strobe.
- **Write data:** shift `01_0011_1100` → `rx_data=0x13C`, one `rx_valid` pulse, `MISO` stays 0.
- **Read sequence:**
  - Frame A `10_0000_0111` → `rx_data=0x207` and `rd_addr_seen=1`.
  - Frame B `11_0000_0000` → `rx_data=0x300`.
  - Drive `tx_valid=1` with `tx_data=0xC3` two cycles later → `MISO` is 1,1,0,0,0,0,1,1 on consecutive cycles starting at the `tx_valid` edge, then 0, and `rd_addr_seen=0`.
- **Read data without a prior address:** with `rd_addr_seen=0`, shift `11_0101_0101` → handled as READ_ADD. `rx_data=0x355`, `rd_addr_seen=1`, and no `MISO` activity even if `tx_valid` pulses.
- **Abort:** raise `SS_n` after 5 bits of a write → no `rx_valid` and `rx_data` unchanged. An immediate new frame `01_1111_0000` → `rx_data=0x1F0` with correct timing.
